// File: rtl/keen_operand_fetch.sv
// rtl/keen_operand_fetch.sv - operand fetch stage with register scoreboard and writeback bypass
//
// Accepts one decoded instruction at a time, reads its two source operands
// from an external synchronous register file, and presents an operand bundle
// on a valid/ready output.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   in_valid/in_ready               instruction handshake
//   in_rs1, in_rs2, in_rd           source / destination register addresses
//   in_rd_write                     instruction writes in_rd
//   rf_read_address_0/1             register file read addresses (= in_rs1/in_rs2)
//   rf_read_data_0/1                register file read data, one cycle after address
//   wb_valid, wb_address, wb_data   writeback port
//   out_valid/out_ready             operand bundle handshake
//   out_rs1_data, out_rs2_data      operand values
//   out_rd, out_rd_write            destination passed through
module keen_operand_fetch #(
    parameter int REGISTERS = 32,
    parameter int WORD_SIZE = 32,
    localparam int ADDRESS_SIZE = $clog2(REGISTERS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDRESS_SIZE-1:0] in_rs1,
    input  logic [ADDRESS_SIZE-1:0] in_rs2,
    input  logic [ADDRESS_SIZE-1:0] in_rd,
    input  logic                    in_rd_write,
    output logic [ADDRESS_SIZE-1:0] rf_read_address_0,
    output logic [ADDRESS_SIZE-1:0] rf_read_address_1,
    input  logic [WORD_SIZE-1:0]    rf_read_data_0,
    input  logic [WORD_SIZE-1:0]    rf_read_data_1,
    input  logic                    wb_valid,
    input  logic [ADDRESS_SIZE-1:0] wb_address,
    input  logic [WORD_SIZE-1:0]    wb_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_SIZE-1:0]    out_rs1_data,
    output logic [WORD_SIZE-1:0]    out_rs2_data,
    output logic [ADDRESS_SIZE-1:0] out_rd,
    output logic                    out_rd_write
);

    logic [REGISTERS-1:0]    scoreboard_q, scoreboard_d;
    logic                    pending_q, pending_d;
    logic [ADDRESS_SIZE-1:0] pend_rs1_q, pend_rs1_d;
    logic [ADDRESS_SIZE-1:0] pend_rs2_q, pend_rs2_d;
    logic [ADDRESS_SIZE-1:0] pend_rd_q, pend_rd_d;
    logic                    pend_rd_write_q, pend_rd_write_d;
    logic                    byp0_flag_q, byp0_flag_d;
    logic                    byp1_flag_q, byp1_flag_d;
    logic [WORD_SIZE-1:0]    byp0_value_q, byp0_value_d;
    logic [WORD_SIZE-1:0]    byp1_value_q, byp1_value_d;
    logic                    out_valid_q, out_valid_d;
    logic [WORD_SIZE-1:0]    out_rs1_data_q, out_rs1_data_d;
    logic [WORD_SIZE-1:0]    out_rs2_data_q, out_rs2_data_d;
    logic [ADDRESS_SIZE-1:0] out_rd_q, out_rd_d;
    logic                    out_rd_write_q, out_rd_write_d;

    logic hz_rs1, hz_rs2, hz_rd, hazard, accept;
    logic wb_hit_rs1, wb_hit_rs2;

    assign rf_read_address_0 = in_rs1;
    assign rf_read_address_1 = in_rs2;

    // A writeback landing this cycle on the register resolves its hazard,
    // since the value can be captured straight off the writeback port.
    assign wb_hit_rs1 = wb_valid && (wb_address == in_rs1) && (in_rs1 != '0);
    assign wb_hit_rs2 = wb_valid && (wb_address == in_rs2) && (in_rs2 != '0);

    assign hz_rs1 = (in_rs1 != '0) && scoreboard_q[in_rs1] && !wb_hit_rs1;
    assign hz_rs2 = (in_rs2 != '0) && scoreboard_q[in_rs2] && !wb_hit_rs2;
    assign hz_rd  = in_rd_write && (in_rd != '0) && scoreboard_q[in_rd]
                    && !(wb_valid && (wb_address == in_rd));
    assign hazard = hz_rs1 || hz_rs2 || hz_rd;

    assign in_ready = !reset && !pending_q && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        scoreboard_d    = scoreboard_q;
        pending_d       = pending_q;
        pend_rs1_d      = pend_rs1_q;
        pend_rs2_d      = pend_rs2_q;
        pend_rd_d       = pend_rd_q;
        pend_rd_write_d = pend_rd_write_q;
        byp0_flag_d     = byp0_flag_q;
        byp1_flag_d     = byp1_flag_q;
        byp0_value_d    = byp0_value_q;
        byp1_value_d    = byp1_value_q;
        out_valid_d     = out_valid_q;
        out_rs1_data_d  = out_rs1_data_q;
        out_rs2_data_d  = out_rs2_data_q;
        out_rd_d        = out_rd_q;
        out_rd_write_d  = out_rd_write_q;

        // Clear first, then set, so a same-cycle set of the same bit wins.
        if (wb_valid && (wb_address != '0)) begin
            scoreboard_d[wb_address] = 1'b0;
        end
        if (accept && in_rd_write && (in_rd != '0)) begin
            scoreboard_d[in_rd] = 1'b1;
        end
        scoreboard_d[0] = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            pending_d       = 1'b1;
            pend_rs1_d      = in_rs1;
            pend_rs2_d      = in_rs2;
            pend_rd_d       = in_rd;
            pend_rd_write_d = in_rd_write;
            byp0_flag_d     = wb_hit_rs1;
            byp1_flag_d     = wb_hit_rs2;
            byp0_value_d    = wb_data;
            byp1_value_d    = wb_data;
        end else if (pending_q) begin
            // The register file read issued at acceptance is available now.
            // in_ready guarantees the output slot is free by this point.
            pending_d      = 1'b0;
            out_valid_d    = 1'b1;
            out_rs1_data_d = (pend_rs1_q == '0) ? '0 :
                             (byp0_flag_q ? byp0_value_q : rf_read_data_0);
            out_rs2_data_d = (pend_rs2_q == '0) ? '0 :
                             (byp1_flag_q ? byp1_value_q : rf_read_data_1);
            out_rd_d       = pend_rd_q;
            out_rd_write_d = pend_rd_write_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scoreboard_q    <= '0;
            pending_q       <= 1'b0;
            pend_rs1_q      <= '0;
            pend_rs2_q      <= '0;
            pend_rd_q       <= '0;
            pend_rd_write_q <= 1'b0;
            byp0_flag_q     <= 1'b0;
            byp1_flag_q     <= 1'b0;
            byp0_value_q    <= '0;
            byp1_value_q    <= '0;
            out_valid_q     <= 1'b0;
            out_rs1_data_q  <= '0;
            out_rs2_data_q  <= '0;
            out_rd_q        <= '0;
            out_rd_write_q  <= 1'b0;
        end else begin
            scoreboard_q    <= scoreboard_d;
            pending_q       <= pending_d;
            pend_rs1_q      <= pend_rs1_d;
            pend_rs2_q      <= pend_rs2_d;
            pend_rd_q       <= pend_rd_d;
            pend_rd_write_q <= pend_rd_write_d;
            byp0_flag_q     <= byp0_flag_d;
            byp1_flag_q     <= byp1_flag_d;
            byp0_value_q    <= byp0_value_d;
            byp1_value_q    <= byp1_value_d;
            out_valid_q     <= out_valid_d;
            out_rs1_data_q  <= out_rs1_data_d;
            out_rs2_data_q  <= out_rs2_data_d;
            out_rd_q        <= out_rd_d;
            out_rd_write_q  <= out_rd_write_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_rs1_data = out_rs1_data_q;
    assign out_rs2_data = out_rs2_data_q;
    assign out_rd       = out_rd_q;
    assign out_rd_write = out_rd_write_q;

endmodule
